// File: rtl/block_packer_if.sv
// block_packer_if: FIFO-side and block-side handshake bundle for block_packer
interface block_packer_if #(
    parameter int BYTE_W      = 8,
    parameter int BLOCK_BYTES = 16
);
    logic                               fifo_empty;
    logic [BYTE_W-1:0]                  fifo_data;
    logic                               fifo_last;
    logic                               pop;
    logic                               blk_valid;
    logic                               blk_ready;
    logic [BYTE_W*BLOCK_BYTES-1:0]      blk_data;
    logic [$clog2(BLOCK_BYTES+1)-1:0]   blk_nbytes;
    logic                               blk_last;
    modport master (
        input  fifo_empty, fifo_data, fifo_last, blk_ready,
        output pop, blk_valid, blk_data, blk_nbytes, blk_last
    );
    modport slave (
        output fifo_empty, fifo_data, fifo_last, blk_ready,
        input  pop, blk_valid, blk_data, blk_nbytes, blk_last
    );
endinterface

// File: rtl/block_packer.sv
// block_packer: packs FIFO bytes MSB-first into blocks with zero or PKCS#7 padding
module block_packer #(
    parameter int BYTE_W      = 8,
    parameter int BLOCK_BYTES = 16,
    parameter int PAD_MODE    = 0
) (
    input  logic           clk,
    input  logic           rst,
    block_packer_if.master bus
);
    localparam int CW = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

    state_t                                state, state_n;
    logic [CW-1:0]                         cnt;
    logic                                  pad_pend;
    logic                                  pop;
    logic                                  valid;
    logic                                  last_slot;
    logic [BYTE_W-1:0]                     pad_val;
    logic [BLOCK_BYTES-1:0][BYTE_W-1:0]    work, fill_word, pad_word, data_q;
    logic [CW-1:0]                         nbytes_q;
    logic                                  last_q;

    assign last_slot = cnt == CW'(BLOCK_BYTES - 1);
    assign pad_val   = PAD_MODE != 0 ? BYTE_W'(BLOCK_BYTES - int'(cnt)) : '0;

    // Slot s lives at packed index BLOCK_BYTES-1-s so slot 0 lands in the MSBs.
    always_comb begin
        fill_word = work;
        pad_word  = work;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i == int'(cnt)) fill_word[BLOCK_BYTES-1-i] = bus.fifo_data;
            if (i >= int'(cnt)) pad_word[BLOCK_BYTES-1-i] = pad_val;
        end
    end

    always_ff @(posedge clk) state <= rst ? FILL : state_n;

    always_comb begin
        state_n = state;
        case (state)
            FILL:    if (pop) state_n = last_slot ? HOLD : bus.fifo_last ? PAD : FILL;
            PAD:     state_n = HOLD;
            HOLD:    if (bus.blk_ready) state_n = pad_pend ? PAD : FILL;
            default: state_n = FILL;
        endcase
    end

    always_comb begin
        pop   = !rst && state == FILL && !bus.fifo_empty;
        valid = state == HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pad_pend <= 1'b0;
            work     <= '0;
            data_q   <= '0;
            nbytes_q <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                FILL: if (pop) begin
                    work <= fill_word;
                    cnt  <= cnt + 1'b1;
                    if (last_slot) begin
                        data_q   <= fill_word;
                        nbytes_q <= CW'(BLOCK_BYTES);
                        last_q   <= bus.fifo_last && PAD_MODE == 0;
                        pad_pend <= bus.fifo_last && PAD_MODE != 0;
                    end else if (bus.fifo_last) begin
                        nbytes_q <= cnt + 1'b1;
                    end
                end
                PAD: begin
                    data_q <= pad_word;
                    last_q <= 1'b1;
                end
                HOLD: if (bus.blk_ready) begin
                    cnt <= '0;
                    if (pad_pend) begin
                        pad_pend <= 1'b0;
                        nbytes_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pop        = pop;
    assign bus.blk_valid  = valid;
    assign bus.blk_data   = data_q;
    assign bus.blk_nbytes = nbytes_q;
    assign bus.blk_last   = last_q;
endmodule

// File: tb/tb_block_packer.sv
// tb_block_packer: random scoreboard bench running zero-pad and PKCS#7 packers side by side
module tb_block_packer;
    localparam int BW = 8;
    localparam int BB = 16;
    localparam int NW = $clog2(BB + 1);

    typedef struct packed {
        logic [BB*BW-1:0] data;
        logic [NW-1:0]    nbytes;
        logic             last;
    } blk_t;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          last;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    always #5 clk = ~clk;

    block_packer_if #(.BYTE_W(BW), .BLOCK_BYTES(BB)) b0 ();
    block_packer_if #(.BYTE_W(BW), .BLOCK_BYTES(BB)) b1 ();

    block_packer #(.BYTE_W(BW), .BLOCK_BYTES(BB), .PAD_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    block_packer #(.BYTE_W(BW), .BLOCK_BYTES(BB), .PAD_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    ent_t f0[$], f1[$];
    blk_t e0[$], e1[$];
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;
    bit   timed_out = 1'b0;
    bit   to_seen = 1'b0;
    int   ready_mode = 1;

    // Reference: chop the message into BB-byte chunks, pad the tail by the mode's rule.
    function automatic void expect_msg(input logic [BW-1:0] msg[$], input bit term, input int mode, output blk_t out[$]);
        int   n;
        int   len;
        blk_t b;
        out = {};
        n = msg.size();
        for (int s = 0; s < n; s += BB) begin
            len = (n - s < BB) ? n - s : BB;
            b = '0;
            for (int j = 0; j < BB; j++)
                b.data[(BB-1-j)*BW +: BW] = j < len ? msg[s+j] : (mode != 0 ? BW'(BB - len) : '0);
            b.nbytes = NW'(len);
            b.last = term && (s + BB >= n) && (mode == 0 || len < BB);
            out.push_back(b);
        end
        if (term && mode == 1 && n % BB == 0) begin
            for (int j = 0; j < BB; j++) b.data[j*BW +: BW] = BW'(BB);
            b.nbytes = '0;
            b.last = 1'b1;
            out.push_back(b);
        end
    endfunction

    task automatic push_raw(input logic [BW-1:0] msg[$], input bit term);
        for (int i = 0; i < msg.size(); i++) begin
            f0.push_back({msg[i], term && i == msg.size() - 1});
            f1.push_back({msg[i], term && i == msg.size() - 1});
        end
    endtask

    task automatic send(input logic [BW-1:0] msg[$], input bit term);
        blk_t x[$];
        expect_msg(msg, term, 0, x);
        foreach (x[i]) e0.push_back(x[i]);
        expect_msg(msg, term, 1, x);
        foreach (x[i]) e1.push_back(x[i]);
        push_raw(msg, term);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (!(f0.size() == 0 && f1.size() == 0 && e0.size() == 0 && e1.size() == 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) timed_out = 1'b1;
        tick();
    endtask

    // FIFO model: pop decisions are sampled mid-cycle, the head is refreshed after each edge.
    initial begin
        bit p0, p1;
        b0.fifo_empty = 1'b1; b0.fifo_data = '0; b0.fifo_last = 1'b0;
        b1.fifo_empty = 1'b1; b1.fifo_data = '0; b1.fifo_last = 1'b0;
        forever begin
            @(negedge clk);
            p0 = b0.pop === 1'b1;
            p1 = b1.pop === 1'b1;
            @(posedge clk);
            if (p0 && f0.size() != 0) void'(f0.pop_front());
            if (p1 && f1.size() != 0) void'(f1.pop_front());
            #1;
            b0.fifo_empty = f0.size() == 0;
            b0.fifo_data  = f0.size() != 0 ? f0[0].d : '0;
            b0.fifo_last  = f0.size() != 0 ? f0[0].last : 1'b0;
            b1.fifo_empty = f1.size() == 0;
            b1.fifo_data  = f1.size() != 0 ? f1[0].d : '0;
            b1.fifo_last  = f1.size() != 0 ? f1[0].last : 1'b0;
        end
    end

    initial begin
        b0.blk_ready = 1'b0;
        b1.blk_ready = 1'b0;
        forever begin
            tick();
            b0.blk_ready = ready_mode == 1 || (ready_mode == 0 && $urandom_range(0, 3) != 0);
            b1.blk_ready = ready_mode == 1 || (ready_mode == 0 && $urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_lane(input string tag, input logic valid, input logic ready, input logic pop,
                              input blk_t cur, input bit have, input blk_t exp,
                              inout bit pend, inout bit acc, inout blk_t saved);
        if (acc) chk({tag, "_valid_drop"}, 256'(valid), 0);
        if (pend) begin
            chk({tag, "_hold_valid"}, 256'(valid), 1);
            chk({tag, "_hold_stable"}, 256'(cur), 256'(saved));
        end
        if (valid === 1'b1) chk({tag, "_pop_in_hold"}, 256'(pop), 0);
        if (valid === 1'b1 && ready === 1'b1) begin
            if (!have) chk({tag, "_unexpected_block"}, 1, 0);
            else begin
                chk({tag, "_data"}, 256'(cur.data), 256'(exp.data));
                chk({tag, "_nbytes"}, 256'(cur.nbytes), 256'(exp.nbytes));
                chk({tag, "_last"}, 256'(cur.last), 256'(exp.last));
            end
        end
        pend = valid === 1'b1 && ready !== 1'b1;
        acc = valid === 1'b1 && ready === 1'b1;
        saved = cur;
    endtask

    always @(posedge clk) rst_q <= rst;

    initial begin
        bit   pend0 = 0, acc0 = 0, pend1 = 0, acc1 = 0, h0, h1;
        blk_t s0 = '0, s1 = '0, c0, c1, x0, x1;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("pop0_in_reset", 256'(b0.pop), 0);
                chk("pop1_in_reset", 256'(b1.pop), 0);
            end
            c0 = {b0.blk_data, b0.blk_nbytes, b0.blk_last};
            c1 = {b1.blk_data, b1.blk_nbytes, b1.blk_last};
            if (rst_q) begin
                chk("lane0_reset_outputs", 256'({b0.blk_valid, c0}), 0);
                chk("lane1_reset_outputs", 256'({b1.blk_valid, c1}), 0);
                pend0 = 0; acc0 = 0; pend1 = 0; acc1 = 0;
            end else begin
                h0 = e0.size() != 0;
                h1 = e1.size() != 0;
                x0 = h0 ? e0[0] : '0;
                x1 = h1 ? e1[0] : '0;
                check_lane("lane0", b0.blk_valid, b0.blk_ready, b0.pop, c0, h0, x0, pend0, acc0, s0);
                check_lane("lane1", b1.blk_valid, b1.blk_ready, b1.pop, c1, h1, x1, pend1, acc1, s1);
                if (acc0 && h0) void'(e0.pop_front());
                if (acc1 && h1) void'(e1.pop_front());
            end
            if (timed_out && !to_seen) begin
                to_seen = 1'b1;
                chk("idle_timeout", 1, 0);
            end
            if (done) begin
                chk("lane0_blocks_left", 256'(e0.size()), 0);
                chk("lane1_blocks_left", 256'(e1.size()), 0);
                chk("fifo_bytes_left", 256'(f0.size() + f1.size()), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] m[$];
        int n;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        m = {};
        for (int i = 0; i < BB; i++) m.push_back(BW'(i));
        send(m, 1'b0);
        wait_idle();
        ready_mode = 2;
        m = {};
        for (int i = 0; i < BB; i++) m.push_back(BW'(8'h10 + i));
        send(m, 1'b0);
        n = 0;
        while (!(b0.blk_valid === 1'b1 && b1.blk_valid === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timed_out = 1'b1;
        m = {};
        for (int i = 0; i < BB; i++) m.push_back(BW'(8'h40 + i));
        send(m, 1'b0);
        repeat (5) tick();
        ready_mode = 1;
        wait_idle();
        m = {8'hAA, 8'hBB, 8'hCC};
        send(m, 1'b1);
        wait_idle();
        m = {};
        for (int i = 0; i < BB; i++) m.push_back(BW'(8'h80 + i));
        send(m, 1'b1);
        wait_idle();
        m = {};
        for (int i = 0; i < 7; i++) m.push_back(BW'(8'hE0 + i));
        push_raw(m, 1'b0);
        wait_idle();
        rst = 1'b1;
        m = {};
        for (int i = 0; i < 20; i++) m.push_back(BW'(8'h50 + i));
        send(m, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        wait_idle();
        ready_mode = 0;
        for (int k = 0; k < 30; k++) begin
            m = {};
            n = ($urandom_range(0, 4) == 0) ? BB * $urandom_range(1, 2) : $urandom_range(1, 40);
            for (int i = 0; i < n; i++) m.push_back(BW'($urandom));
            send(m, 1'b1);
            repeat ($urandom_range(0, 5)) tick();
        end
        wait_idle();
        ready_mode = 1;
        tick();
        done = 1'b1;
    end
endmodule
